// File: rtl/ee271_change_dispenser.sv
// ee271_change_dispenser: greedy coin change dispenser with refillable inventory and ready/valid coin ejection
module ee271_change_dispenser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       chg_valid,
  input  logic [5:0] chg_amt,
  output logic       chg_ready,
  output logic [2:0] coin_out,
  output logic       coin_valid,
  input  logic       coin_ready,
  input  logic       refill_valid,
  input  logic [3:0] refill_q,
  input  logic [3:0] refill_d,
  input  logic [3:0] refill_n,
  output logic       done,
  output logic       short_chg,
  output logic [5:0] rem_amt,
  output logic       err,
  output logic [3:0] q_cnt,
  output logic [3:0] d_cnt,
  output logic [3:0] n_cnt
);
  typedef enum logic [2:0] {IDLE, SEL, DISP, DONE, SHORT} state_t;
  state_t state_q, state_d;
  logic [5:0] rem_q, rem_d, rem_amt_q, rem_amt_d, coin_val;
  logic [2:0] coin_q, coin_d;
  logic [3:0] q_cnt_q, q_cnt_d, d_cnt_q, d_cnt_d, n_cnt_q, n_cnt_d;
  logic coin_valid_q, coin_valid_d, done_q, done_d, short_q, short_d, err_q, err_d;
  logic legal, pick_q, pick_d, pick_n;
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hf : s[3:0];
  endfunction
  assign legal = (chg_amt % 6'd5 == 6'd0) && (chg_amt <= 6'd55);
  assign pick_q = (rem_q >= 6'd25) && (q_cnt_q != 4'd0);
  assign pick_d = (rem_q >= 6'd10) && (d_cnt_q != 4'd0);
  assign pick_n = (rem_q >= 6'd5) && (n_cnt_q != 4'd0);
  assign coin_val = coin_q[2] ? 6'd25 : coin_q[1] ? 6'd10 : 6'd5;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    coin_d = coin_q;
    coin_valid_d = coin_valid_q;
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    done_d = state_q == DONE;
    short_d = state_q == SHORT;
    rem_amt_d = state_q == SHORT ? rem_q : 6'd0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_valid) begin
          q_cnt_d = sat_add(q_cnt_q, refill_q);
          d_cnt_d = sat_add(d_cnt_q, refill_d);
          n_cnt_d = sat_add(n_cnt_q, refill_n);
        end
        if (chg_valid) begin
          err_d = !legal;
          rem_d = legal ? chg_amt : rem_q;
          state_d = !legal ? IDLE : chg_amt == 6'd0 ? DONE : SEL;
        end
      end
      SEL: begin
        coin_d = pick_q ? 3'b100 : pick_d ? 3'b010 : pick_n ? 3'b001 : 3'b000;
        coin_valid_d = pick_q || pick_d || pick_n;
        state_d = coin_valid_d ? DISP : SHORT;
      end
      DISP: begin
        if (coin_ready) begin
          rem_d = rem_q - coin_val;
          q_cnt_d = q_cnt_q - {3'b0, coin_q[2]};
          d_cnt_d = d_cnt_q - {3'b0, coin_q[1]};
          n_cnt_d = n_cnt_q - {3'b0, coin_q[0]};
          coin_d = 3'b000;
          coin_valid_d = 1'b0;
          state_d = rem_d == 6'd0 ? DONE : SEL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= 6'd0;
      rem_amt_q <= 6'd0;
      coin_q <= 3'b000;
      coin_valid_q <= 1'b0;
      q_cnt_q <= 4'd0;
      d_cnt_q <= 4'd0;
      n_cnt_q <= 4'd0;
      done_q <= 1'b0;
      short_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      rem_amt_q <= rem_amt_d;
      coin_q <= coin_d;
      coin_valid_q <= coin_valid_d;
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
      done_q <= done_d;
      short_q <= short_d;
      err_q <= err_d;
    end
  end
  assign chg_ready = state_q == IDLE;
  assign coin_out = coin_q;
  assign coin_valid = coin_valid_q;
  assign done = done_q;
  assign short_chg = short_q;
  assign rem_amt = rem_amt_q;
  assign err = err_q;
  assign q_cnt = q_cnt_q;
  assign d_cnt = d_cnt_q;
  assign n_cnt = n_cnt_q;
endmodule
